// File: rtl/icache_nway_burst.sv
// icache_nway_burst: N-way set-associative I-cache, multi-word lines,
// burst refill, RR or tree-PLRU replacement, whole-cache flush.
// Ports: clk/rst_n; cpu_req/cpu_addr in, cpu_data/cpu_valid/cpu_stall out;
// flush in, flush_busy out; mem_req/mem_addr out, mem_data/mem_valid in;
// cache_hit/cache_miss/cache_evict one-cycle statistic pulses.
module icache_nway_burst #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_SETS      = 64,
  parameter int ASSOCIATIVITY = 4,
  parameter int LINE_WORDS    = 4,
  parameter int REPL_POLICY   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_valid,
  output logic                  cpu_stall,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_valid,
  output logic                  cache_hit,
  output logic                  cache_miss,
  output logic                  cache_evict
);
  localparam int OFF = 2 + $clog2(LINE_WORDS);
  localparam int SW  = $clog2(NUM_SETS);
  localparam int TW  = ADDR_WIDTH - OFF - SW;
  localparam int WW  = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
  localparam int LG  = $clog2(ASSOCIATIVITY);
  localparam int YW  = ASSOCIATIVITY > 1 ? LG : 1;
  localparam int PW  = ASSOCIATIVITY > 1 ? ASSOCIATIVITY - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_FLUSH} state_t;

  logic [TW-1:0]         tag_q   [NUM_SETS][ASSOCIATIVITY];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][ASSOCIATIVITY][LINE_WORDS];
  logic [ASSOCIATIVITY-1:0] valid_q [NUM_SETS];
  logic [YW-1:0]         rr_q    [NUM_SETS];
  logic [PW-1:0]         plru_q  [NUM_SETS];

  state_t                state_q;
  logic                  pend_q;
  logic [SW-1:0]         set_q;
  logic [SW-1:0]         fset_q;
  logic [WW-1:0]         word_q;
  logic [WW-1:0]         cnt_q;
  logic [YW-1:0]         way_q;
  logic                  evict_q;
  logic [ADDR_WIDTH-1:0] line_q;

  logic [WW-1:0]         a_word;
  logic [SW-1:0]         a_set;
  logic [TW-1:0]         a_tag;
  logic [ADDR_WIDTH-1:0] a_line;
  logic                  hit;
  logic [YW-1:0]         hit_way;
  logic [YW-1:0]         vict;
  logic                  fl_now;
  logic                  hit_go;
  logic                  miss_go;
  logic                  last;

  // Heap-ordered tree: node n has children 2n and 2n+1; bit n-1
  // names the side (0 left, 1 right) holding the next victim.
  function automatic logic [YW-1:0] plru_pick(input logic [PW-1:0] b);
    int n;
    n = 1;
    for (int l = 0; l < LG; l++) n = 2 * n + int'(b[n-1]);
    return YW'(n - ASSOCIATIVITY);
  endfunction

  function automatic logic [PW-1:0] plru_touch(
    input logic [PW-1:0] b,
    input logic [YW-1:0] w
  );
    logic [PW-1:0] r;
    logic d;
    int n;
    r = b;
    n = 1;
    for (int l = 0; l < LG; l++) begin
      d = w[LG-1-l];
      r[n-1] = ~d;
      n = 2 * n + int'(d);
    end
    return r;
  endfunction

  assign a_word = LINE_WORDS > 1 ? WW'(cpu_addr >> 2) : '0;
  assign a_set  = SW'(cpu_addr >> OFF);
  assign a_tag  = TW'(cpu_addr >> (OFF + SW));
  assign a_line = cpu_addr & ~ADDR_WIDTH'(4 * LINE_WORDS - 1);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vict    = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (valid_q[a_set][w] && tag_q[a_set][w] == a_tag) begin
        hit     = 1'b1;
        hit_way = YW'(w);
      end
    end
    if (&valid_q[a_set]) begin
      vict = (REPL_POLICY == 1) ? plru_pick(plru_q[a_set]) : rr_q[a_set];
    end else begin
      for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
        if (!valid_q[a_set][w]) vict = YW'(w);
      end
    end
  end

  assign fl_now     = flush || pend_q;
  assign hit_go     = cpu_req && hit && !fl_now;
  assign miss_go    = cpu_req && !hit && !fl_now;
  assign last       = cnt_q == WW'(LINE_WORDS - 1);
  assign mem_req    = state_q == S_REFILL;
  assign mem_addr   = line_q;
  assign flush_busy = pend_q || state_q == S_FLUSH;
  assign cpu_stall  = state_q != S_IDLE || fl_now || (cpu_req && !hit);

  // Tag and line storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && miss_go) tag_q[a_set][vict] <= a_tag;
    if (state_q == S_REFILL && mem_valid)
      data_q[set_q][way_q][cnt_q] <= mem_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      set_q       <= '0;
      fset_q      <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      way_q       <= '0;
      evict_q     <= 1'b0;
      line_q      <= '0;
      cpu_data    <= '0;
      cpu_valid   <= 1'b0;
      cache_hit   <= 1'b0;
      cache_miss  <= 1'b0;
      cache_evict <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      cpu_valid   <= 1'b0;
      cache_hit   <= 1'b0;
      cache_miss  <= 1'b0;
      cache_evict <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          unique case (1'b1)
            fl_now: begin
              state_q <= S_FLUSH;
              pend_q  <= 1'b0;
              fset_q  <= '0;
            end
            hit_go: begin
              cpu_valid     <= 1'b1;
              cache_hit     <= 1'b1;
              cpu_data      <= data_q[a_set][hit_way][a_word];
              plru_q[a_set] <= plru_touch(plru_q[a_set], hit_way);
            end
            miss_go: begin
              state_q <= S_REFILL;
              set_q   <= a_set;
              word_q  <= a_word;
              way_q   <= vict;
              evict_q <= valid_q[a_set][vict];
              line_q  <= a_line;
              cnt_q   <= '0;
              valid_q[a_set][vict] <= 1'b0;
            end
            default: ;
          endcase
        end
        S_REFILL: begin
          if (flush) pend_q <= 1'b1;
          if (mem_valid) begin
            if (cnt_q == word_q) cpu_data <= mem_data;
            cnt_q <= cnt_q + WW'(1);
            if (last) begin
              valid_q[set_q][way_q] <= 1'b1;
              plru_q[set_q] <= plru_touch(plru_q[set_q], way_q);
              if (rr_q[set_q] == YW'(ASSOCIATIVITY - 1))
                rr_q[set_q] <= '0;
              else
                rr_q[set_q] <= rr_q[set_q] + YW'(1);
              cpu_valid   <= 1'b1;
              cache_miss  <= 1'b1;
              cache_evict <= evict_q;
              if (fl_now) begin
                state_q <= S_FLUSH;
                pend_q  <= 1'b0;
                fset_q  <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
        end
        S_FLUSH: begin
          valid_q[fset_q] <= '0;
          rr_q[fset_q]    <= '0;
          plru_q[fset_q]  <= '0;
          fset_q          <= fset_q + SW'(1);
          if (fset_q == SW'(NUM_SETS - 1)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_nway_burst.sv
// tb_icache_nway_burst: directed bench for icache_nway_burst covering
// RR, PLRU and a direct-mapped single-word-line configuration.
module tb_icache_nway_burst;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_valid = 1'b0;
  int          sel = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] data_o  [3];
  logic [31:0] maddr_o [3];
  logic [2:0]  valid_v, stall_v, fb_v, mreq_v, hit_v, miss_v, ev_v;

  logic [31:0] o_data, o_maddr;
  logic        o_valid, o_stall, o_fb, o_mreq, o_hit, o_miss, o_ev;

  assign o_data  = data_o[sel];
  assign o_maddr = maddr_o[sel];
  assign o_valid = valid_v[sel];
  assign o_stall = stall_v[sel];
  assign o_fb    = fb_v[sel];
  assign o_mreq  = mreq_v[sel];
  assign o_hit   = hit_v[sel];
  assign o_miss  = miss_v[sel];
  assign o_ev    = ev_v[sel];

  always #5 clk = ~clk;

  icache_nway_burst #(.REPL_POLICY(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(req && sel == 0), .cpu_addr(cpu_addr),
    .cpu_data(data_o[0]), .cpu_valid(valid_v[0]), .cpu_stall(stall_v[0]),
    .flush(flush && sel == 0), .flush_busy(fb_v[0]),
    .mem_req(mreq_v[0]), .mem_addr(maddr_o[0]),
    .mem_data(mem_data), .mem_valid(mem_valid && sel == 0),
    .cache_hit(hit_v[0]), .cache_miss(miss_v[0]), .cache_evict(ev_v[0])
  );

  icache_nway_burst #(.REPL_POLICY(1)) u_pl (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(req && sel == 1), .cpu_addr(cpu_addr),
    .cpu_data(data_o[1]), .cpu_valid(valid_v[1]), .cpu_stall(stall_v[1]),
    .flush(flush && sel == 1), .flush_busy(fb_v[1]),
    .mem_req(mreq_v[1]), .mem_addr(maddr_o[1]),
    .mem_data(mem_data), .mem_valid(mem_valid && sel == 1),
    .cache_hit(hit_v[1]), .cache_miss(miss_v[1]), .cache_evict(ev_v[1])
  );

  icache_nway_burst #(.ASSOCIATIVITY(1), .LINE_WORDS(1)) u_dg (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(req && sel == 2), .cpu_addr(cpu_addr),
    .cpu_data(data_o[2]), .cpu_valid(valid_v[2]), .cpu_stall(stall_v[2]),
    .flush(flush && sel == 2), .flush_busy(fb_v[2]),
    .mem_req(mreq_v[2]), .mem_addr(maddr_o[2]),
    .mem_data(mem_data), .mem_valid(mem_valid && sel == 2),
    .cache_hit(hit_v[2]), .cache_miss(miss_v[2]), .cache_evict(ev_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_chk(input string t);
    chk({t, "_valid"}, o_valid, 0);
    chk({t, "_data"}, o_data, 0);
    chk({t, "_stall"}, o_stall, 0);
    chk({t, "_mreq"}, o_mreq, 0);
    chk({t, "_maddr"}, o_maddr, 0);
    chk({t, "_fbusy"}, o_fb, 0);
    chk({t, "_hit"}, o_hit, 0);
    chk({t, "_miss"}, o_miss, 0);
    chk({t, "_evict"}, o_ev, 0);
  endtask

  task automatic miss(input logic [31:0] a, input int nw,
                      input logic [31:0] d0, input int gap,
                      input logic ev, input logic [31:0] expd);
    logic [31:0] base;
    base = a & ~32'(nw * 4 - 1);
    cpu_addr = a;
    req = 1'b1;
    #1;
    chk("miss_stall_req", o_stall, 1);
    chk("miss_mreq_req", o_mreq, 0);
    cyc;
    chk("miss_mreq", o_mreq, 1);
    chk("miss_maddr", o_maddr, base);
    for (int i = 0; i < nw; i++) begin
      for (int g = 0; g < gap; g++) begin
        mem_valid = 1'b0;
        #1;
        chk("gap_stall", o_stall, 1);
        chk("gap_mreq", o_mreq, 1);
        cyc;
      end
      mem_valid = 1'b1;
      mem_data = d0 + 32'(i);
      #1;
      chk("beat_stall", o_stall, 1);
      chk("beat_valid", o_valid, 0);
      cyc;
    end
    mem_valid = 1'b0;
    req = 1'b0;
    #1;
    chk("miss_valid", o_valid, 1);
    chk("miss_data", o_data, expd);
    chk("miss_flag", o_miss, 1);
    chk("miss_evict", o_ev, ev);
    chk("miss_hitflag", o_hit, 0);
    chk("miss_stall_end", o_stall, 0);
    chk("miss_mreq_end", o_mreq, 0);
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] expd);
    cpu_addr = a;
    req = 1'b1;
    #1;
    chk("hit_stall", o_stall, 0);
    cyc;
    req = 1'b0;
    #1;
    chk("hit_valid", o_valid, 1);
    chk("hit_data", o_data, expd);
    chk("hit_flag", o_hit, 1);
    chk("hit_missflag", o_miss, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    sel = 0;
    repeat (2) cyc;
    zero_chk("reset");
    rst_n = 1'b1;
    cyc;

    // cold miss then hit on the same line
    miss(32'h108, 4, 32'hA0, 0, 1'b0, 32'hA2);
    hit(32'h10C, 32'hA3);

    // round-robin: fill set 0, then evict way 0
    miss(32'h000, 4, 32'h1000, 0, 1'b0, 32'h1000);
    miss(32'h400, 4, 32'h2000, 0, 1'b0, 32'h2000);
    miss(32'h800, 4, 32'h3000, 0, 1'b0, 32'h3000);
    miss(32'hC00, 4, 32'h4000, 0, 1'b0, 32'h4000);
    miss(32'h1000, 4, 32'h5000, 0, 1'b1, 32'h5000);
    hit(32'h400, 32'h2000);
    hit(32'h1004, 32'h5001);
    miss(32'h000, 4, 32'h6000, 0, 1'b1, 32'h6000);

    // tree PLRU
    sel = 1;
    miss(32'h000, 4, 32'h1000, 0, 1'b0, 32'h1000);
    miss(32'h400, 4, 32'h2000, 0, 1'b0, 32'h2000);
    miss(32'h800, 4, 32'h3000, 0, 1'b0, 32'h3000);
    miss(32'hC00, 4, 32'h4000, 0, 1'b0, 32'h4000);
    hit(32'h000, 32'h1000);
    miss(32'h1000, 4, 32'h5000, 0, 1'b1, 32'h5000);
    hit(32'h000, 32'h1000);
    hit(32'h404, 32'h2001);
    miss(32'h800, 4, 32'h7000, 0, 1'b1, 32'h7000);

    // flush pulsed in the second refill cycle
    sel = 0;
    cpu_addr = 32'h2208;
    req = 1'b1;
    #1;
    cyc;
    mem_valid = 1'b1;
    mem_data = 32'hB0;
    cyc;
    flush = 1'b1;
    mem_data = 32'hB1;
    cyc;
    flush = 1'b0;
    mem_data = 32'hB2;
    #1;
    chk("fl_busy_pend", o_fb, 1);
    chk("fl_stall_refill", o_stall, 1);
    cyc;
    mem_data = 32'hB3;
    cyc;
    mem_valid = 1'b0;
    req = 1'b0;
    #1;
    chk("fl_refill_valid", o_valid, 1);
    chk("fl_refill_data", o_data, 32'hB2);
    chk("fl_busy_run", o_fb, 1);
    chk("fl_stall_run", o_stall, 1);
    n = 0;
    while (o_fb && n < 200) begin
      n++;
      cyc;
    end
    chk("fl_length", n, 64);
    chk("fl_stall_done", o_stall, 0);
    miss(32'h100, 4, 32'hC0, 0, 1'b0, 32'hC0);
    miss(32'h1000, 4, 32'hC4, 0, 1'b0, 32'hC4);
    miss(32'h000, 4, 32'hC8, 0, 1'b0, 32'hC8);
    miss(32'h2200, 4, 32'hCC, 0, 1'b0, 32'hCC);

    // gapped beats
    miss(32'h3008, 4, 32'hD0, 3, 1'b0, 32'hD2);

    // reset in the middle of a burst
    cpu_addr = 32'h5000;
    req = 1'b1;
    #1;
    cyc;
    mem_valid = 1'b1;
    mem_data = 32'hE0;
    cyc;
    mem_data = 32'hE1;
    cyc;
    mem_valid = 1'b0;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    zero_chk("midrst");
    cyc;
    rst_n = 1'b1;
    cyc;
    miss(32'h5000, 4, 32'hF0, 0, 1'b0, 32'hF0);

    // direct-mapped, single-word lines
    sel = 2;
    miss(32'h40, 1, 32'h77, 0, 1'b0, 32'h77);
    hit(32'h40, 32'h77);
    miss(32'h140, 1, 32'h88, 0, 1'b1, 32'h88);
    miss(32'h40, 1, 32'h99, 0, 1'b1, 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_nway_burst.md
# icache_nway_burst

Parametrised N-way set-associative instruction cache with multi-word lines, burst refill, selectable replacement policy and whole-cache flush. It sits between the fetch stage and the instruction memory port and is the line-based successor of the single-word-line cache. Hits return in one cycle. Misses refill a full line from memory, one beat per `mem_valid`, before responding.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: word width. Word size is fixed at 4 bytes.
- `NUM_SETS`, 64: sets. Power of 2, at least 2.
- `ASSOCIATIVITY`, 4: ways. Allowed values 1, 2, 4, 8.
- `LINE_WORDS`, 4: words per line. Allowed values 1, 2, 4, 8.
- `REPL_POLICY`, 0: 0 = round-robin, 1 = tree pseudo-LRU.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: fetch request.
- `cpu_addr` in ADDR_WIDTH: fetch byte address. Bits [1:0] are ignored.
- `cpu_data` out DATA_WIDTH: fetched word. Registered.
- `cpu_valid` out 1: one-cycle pulse; `cpu_data` is valid.
- `cpu_stall` out 1: combinational; CPU must hold `cpu_addr` while high.
- `flush` in 1: one-cycle pulse; invalidate the whole cache.
- `flush_busy` out 1: high while a flush is pending or running.
- `mem_req` out 1: refill request, combinational.
- `mem_addr` out ADDR_WIDTH: line base address.
- `mem_data` in DATA_WIDTH: refill beat data.
- `mem_valid` in 1: a beat is present this cycle.
- `cache_hit`, `cache_miss`, `cache_evict` out 1: one-cycle statistic pulses.

## Operation
- **Address split:**
  - OFF = 2 + log2(LINE_WORDS).
  - word = addr[OFF-1:2].
  - set = addr[OFF+log2(NUM_SETS)-1:OFF].
  - tag = the remaining upper bits.
- **Storage:** per set and way, a tag, a valid bit and LINE_WORDS data words. Per set, replacement state: a log2(ASSOC) round-robin counter, or ASSOC-1 PLRU tree bits. With ASSOCIATIVITY=1 the replacement state is unused.
- **States:** IDLE, REFILL, FLUSH.
- **IDLE, priority order:**
  1. flush or a pending flush → FLUSH.
  2. cpu_req with hit → respond; stay in IDLE.
  3. cpu_req with miss → REFILL.
- **Victim selection:** the lowest-index invalid way. If all ways are valid, the policy choice:
  - RR: the counter value.
  - PLRU: follow the tree bits from the root; each bit names the side holding the next victim.
- **On miss entry:** latch set, tag, word offset, line base, victim way, and evict = victim was valid. Write the victim's tag and clear its valid bit.
- **REFILL:**
  - `mem_req`=1 and `mem_addr`=line base for the whole state.
  - A beat counter starting at 0 writes each `mem_valid` beat to word[count], in address order.
  - The beat whose count equals the latched word offset is also captured for the response.
  - On the last beat: set the valid bit, update the replacement state, and return to IDLE. If a flush is pending, go to FLUSH instead.
- **Replacement update:**
  - RR: the counter increments on every refill, wrapping from ASSOC-1 to 0. Hits do not change it.
  - PLRU: on every hit and every refill, the bits on the accessed way's path are set to point away from it.
- **flush during REFILL:** set the pending bit. The refill and its response complete first.
- **FLUSH:**
  - Clear the valid bits and replacement state of one set per cycle, from set 0 to NUM_SETS-1.
  - Then return to IDLE.
  - `flush_busy` = pending, or state == FLUSH.
- `mem_valid` outside REFILL is ignored.

## Timing
- **Reset:** all outputs 0, state IDLE, all valid bits, counters and PLRU bits 0, pending flush cleared.
  - Reset during REFILL abandons the burst; memory must discard it.
- **Hit:** request in cycle N with `cpu_stall`=0. In N+1: `cpu_valid`=1, `cpu_data` = the word, `cache_hit`=1. A new request may be presented in N+1.
- **Miss:**
  - `cpu_stall`=1 combinationally from request cycle N through the cycle of the last beat L.
  - `mem_req` is high from N+1 through L.
  - In L+1: `cpu_valid`=1, `cache_miss`=1, `cache_evict` = the latched evict flag, `cpu_stall`=0.
  - Minimum miss latency is LINE_WORDS+1 cycles from request to data.
- **Stall during flush:** `cpu_stall`=1 whenever state is FLUSH, or state is IDLE with flush or pending flush. No hit response is given in those cycles.
- A flush takes exactly NUM_SETS cycles in FLUSH.
- `cpu_valid` and the statistic pulses are otherwise 0.

## Test plan
- **Cold miss with follow-up hit:** defaults; request 0x0000_0108, beats 0xA0,0xA1,0xA2,0xA3.
  - `mem_addr`=0x100; `cpu_valid` with 0xA2; `cache_miss`=1, `cache_evict`=0.
  - Next request 0x10C → `cpu_data`=0xA3 one cycle later, `cache_hit`=1.
- **RR eviction:** REPL_POLICY=0; miss 0x000, 0x400, 0x800, 0xC00 with no evict, then 0x1000.
  - `cache_evict`=1 and way 0 is replaced.
  - A re-access of 0x000 misses; 0x400 hits.
- **PLRU eviction:** REPL_POLICY=1; fill 0x000, 0x400, 0x800, 0xC00; hit 0x000; then miss 0x1000.
  - Victim is 0x800 (way 2).
  - 0x000 and 0x400 still hit; 0x800 misses.
- **Flush during REFILL:** pulse flush in the second REFILL cycle.
  - The refill completes with `cpu_valid`.
  - `flush_busy` stays high; state is FLUSH for 64 cycles.
  - Afterwards every previously cached address misses with `cache_evict`=0.
- **Gapped beats and reset:** insert 3-cycle gaps between `mem_valid` beats.
  - `cpu_stall` and `mem_req` stay high until the last beat, and the data is correct.
  - Repeat, asserting rst_n=0 after beat 2: all outputs 0 immediately; the same address then misses.
- **Degenerate configuration:** ASSOCIATIVITY=1, LINE_WORDS=1.
  - Single-beat refill; response 2 cycles after the request.
  - A conflicting tag evicts (`cache_evict`=1).
